// File: rtl/mtr_pwm_drv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_pkg
//  Description : Shared types and constants for the dual-motor PWM driver.
//                chan_st_t is the per-channel drive state; the C_* constants
//                are the default widths and deadband of the driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package mtr_pkg;

  localparam int C_SPD_W    = 11;                 // signed speed width
  localparam int C_PWM_W    = 10;                 // PWM counter width
  localparam int C_MIN_DUTY = 16;                 // deadband threshold
  localparam int PWM_MAX    = (1 << C_PWM_W) - 1; // last counter value

  typedef enum logic [1:0] {
    STOP = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    GAP  = 2'd3
  } chan_st_t;

endpackage
`default_nettype wire

// File: rtl/mtr_pwm_drv_if.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_pwm_drv_if
//  Description : Signal bundle between the PID / H-bridge side and the PWM
//                driver.
//                  en        drive enable (low forces coast)
//                  lft_spd   signed left wheel speed
//                  rght_spd  signed right wheel speed
//                  lft_fwd / lft_rev    left H-bridge legs
//                  rght_fwd / rght_rev  right H-bridge legs
//                  prd_strt  one-cycle pulse on the first cycle of a period
//                master : drives en/speeds, observes legs (PID / testbench)
//                slave  : the driver itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface mtr_pwm_drv_if
  import mtr_pkg::*;
#(
  parameter int SPD_W = C_SPD_W
) ();

  logic                    en;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    lft_fwd;
  logic                    lft_rev;
  logic                    rght_fwd;
  logic                    rght_rev;
  logic                    prd_strt;

  modport master (
    output en, lft_spd, rght_spd,
    input  lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt
  );

  modport slave (
    input  en, lft_spd, rght_spd,
    output lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt
  );

endinterface
`default_nettype wire

// File: rtl/mtr_pwm_drv_chan.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_pwm_chan
//  Description : One motor channel. Converts a signed speed into magnitude
//                and direction (with saturation and deadband), runs the
//                STOP/FWD/REV/GAP drive FSM at period boundaries, holds the
//                duty shadow register and produces the registered PWM legs.
//  Ports       : clk, rst   clock, asynchronous active-high reset
//                en_i       drive enable; low forces STOP on the next edge
//                bnd_i      high while the shared counter is at its maximum
//                cnt_i      shared PWM counter
//                spd_i      signed speed request
//                fwd_o      forward leg
//                rev_o      reverse leg
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_pwm_chan
  import mtr_pkg::*;
#(
  parameter int SPD_W    = C_SPD_W,
  parameter int PWM_W    = C_PWM_W,
  parameter int MIN_DUTY = C_MIN_DUTY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    bnd_i,
  input  logic [PWM_W-1:0]        cnt_i,
  input  logic signed [SPD_W-1:0] spd_i,
  output logic                    fwd_o,
  output logic                    rev_o
);

  // Largest magnitude the counter can express; the most negative speed
  // has one more unit of magnitude and is clipped to this.
  localparam logic [SPD_W-1:0] C_SAT = SPD_W'((1 << PWM_W) - 1);

  logic [SPD_W-1:0] w_abs;
  logic [PWM_W-1:0] w_mag;
  logic             w_dead;
  chan_st_t         w_req;
  chan_st_t         state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             fwd_q, rev_q;

  always_comb begin
    w_abs  = spd_i[SPD_W-1] ? $unsigned(-spd_i) : $unsigned(spd_i);
    w_mag  = (w_abs > C_SAT) ? {PWM_W{1'b1}} : w_abs[PWM_W-1:0];
    w_dead = (w_mag < PWM_W'(MIN_DUTY));

    w_req = STOP;
    if (!w_dead) begin
      w_req = spd_i[SPD_W-1] ? REV : FWD;
    end
    duty_d = w_dead ? '0 : w_mag;

    // A direct FWD<->REV swap is routed through GAP so both legs coast for
    // one full period before the opposite leg is driven.
    state_d = STOP;
    case (state_q)
      STOP:    state_d = w_req;
      FWD:     state_d = (w_req == REV) ? GAP : w_req;
      REV:     state_d = (w_req == FWD) ? GAP : w_req;
      GAP:     state_d = w_req;
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOP;
      duty_q  <= '0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
    end else if (!en_i) begin
      state_q <= STOP;
      duty_q  <= '0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      if (bnd_i) begin
        state_q <= state_d;
        duty_q  <= duty_d;
      end
      // Compare against the pre-edge count: the pulse shows on cnt 1..duty.
      fwd_q <= (state_q == FWD) && (cnt_i < duty_q);
      rev_q <= (state_q == REV) && (cnt_i < duty_q);
    end
  end

  assign fwd_o = fwd_q;
  assign rev_o = rev_q;

endmodule
`default_nettype wire

// File: rtl/mtr_pwm_drv.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_pwm_drv
//  Description : Dual-motor PWM driver between the PID and the H-bridge pins.
//                Owns the free-running PWM counter, the boundary strobe and
//                the period-start pulse; one mtr_pwm_chan per wheel.
//  Ports       : clk   system clock
//                rst   asynchronous active-high reset
//                bus   mtr_pwm_drv_if.slave (en, speeds, legs, prd_strt)
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_pwm_drv
  import mtr_pkg::*;
#(
  parameter int SPD_W    = C_SPD_W,
  parameter int PWM_W    = C_PWM_W,
  parameter int MIN_DUTY = C_MIN_DUTY
) (
  input  logic         clk,
  input  logic         rst,
  mtr_pwm_drv_if.slave bus
);

  localparam logic [PWM_W-1:0] C_CNT_MAX = {PWM_W{1'b1}};

  logic [PWM_W-1:0] cnt_q;
  logic             prd_strt_q;
  logic             w_bnd;

  assign w_bnd = (cnt_q == C_CNT_MAX);

  // Counter runs regardless of enable so periods stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      prd_strt_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_q + PWM_W'(1);
      prd_strt_q <= (cnt_q == '0);
    end
  end

  assign bus.prd_strt = prd_strt_q;

  mtr_pwm_chan #(
    .SPD_W    (SPD_W),
    .PWM_W    (PWM_W),
    .MIN_DUTY (MIN_DUTY)
  ) u_lft (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.en),
    .bnd_i (w_bnd),
    .cnt_i (cnt_q),
    .spd_i (bus.lft_spd),
    .fwd_o (bus.lft_fwd),
    .rev_o (bus.lft_rev)
  );

  mtr_pwm_chan #(
    .SPD_W    (SPD_W),
    .PWM_W    (PWM_W),
    .MIN_DUTY (MIN_DUTY)
  ) u_rght (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.en),
    .bnd_i (w_bnd),
    .cnt_i (cnt_q),
    .spd_i (bus.rght_spd),
    .fwd_o (bus.rght_fwd),
    .rev_o (bus.rght_rev)
  );

endmodule
`default_nettype wire

// File: tb/tb_mtr_pwm_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtr_pwm_drv
//  Description : Self-checking bench for mtr_pwm_drv. A period-level model
//                (plan of mode + duty per channel, refreshed at boundaries)
//                predicts every output cycle; directed periods pin the model
//                with hand-computed high-time counts; a random phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_pwm_drv;
  import mtr_pkg::*;

  localparam int PERIOD = PWM_MAX + 1;

  logic clk = 1'b0;
  logic rst;

  mtr_pwm_drv_if ifc ();

  mtr_pwm_drv dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 coast, 1 forward, 2 reverse, 3 reversal gap
  int         m_cnt     = 0;
  int         m_mode[2] = '{0, 0};
  int         m_duty[2] = '{0, 0};
  logic [4:0] exp_v     = '0;   // {lf, lr, rf, rr, prd_strt}

  always @(posedge clk or posedge rst) begin : p_model
    int c, s, mag, rq, rd, nm, nd;
    logic [1:0] fw, rv;
    if (rst) begin
      m_cnt  <= 0;
      m_mode <= '{0, 0};
      m_duty <= '{0, 0};
      exp_v  <= '0;
    end else begin
      c = (m_cnt + 1) % PERIOD;   // count visible after this edge
      for (int ch = 0; ch < 2; ch++) begin
        nm = m_mode[ch];
        nd = m_duty[ch];
        if (!ifc.en) begin
          nm = 0;
          nd = 0;
        end else if (m_cnt == PWM_MAX) begin
          if (ch == 0) s = ifc.lft_spd; else s = ifc.rght_spd;
          mag = (s < 0) ? -s : s;
          if (mag > PWM_MAX) mag = PWM_MAX;
          if (mag < C_MIN_DUTY) begin
            rq = 0; rd = 0;
          end else begin
            rq = (s > 0) ? 1 : 2; rd = mag;
          end
          if ((nm == 1 && rq == 2) || (nm == 2 && rq == 1)) nm = 3;
          else nm = rq;
          nd = rd;
        end
        fw[ch] = (nm == 1) && (c >= 1) && (c <= nd);
        rv[ch] = (nm == 2) && (c >= 1) && (c <= nd);
        m_mode[ch] <= nm;
        m_duty[ch] <= nd;
      end
      exp_v <= {fw[0], rv[0], fw[1], rv[1], (c == 1)};
      m_cnt <= c;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : p_cmp
    logic [4:0] act;
    act = {ifc.lft_fwd, ifc.lft_rev, ifc.rght_fwd, ifc.rght_rev, ifc.prd_strt};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: outputs(lf,lr,rf,rr,ps)=%b expected %b",
               $time, act, exp_v);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input int l, input int r);
    ifc.en       = e;
    ifc.lft_spd  = C_SPD_W'(l);
    ifc.rght_spd = C_SPD_W'(r);
  endtask

  task automatic sync_start();
    int n;
    n = 0;
    @(negedge clk);
    while (ifc.prd_strt !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("prd_strt_seen", int'(ifc.prd_strt === 1'b1), 1);
  endtask

  // Counts high cycles of each leg over one period (cnt 1..1023,0) and
  // applies up to two input changes at given sample indices (-1 = none).
  task automatic meas(input int i1, input logic e1, input int l1, input int r1,
                      input int i2, input logic e2, input int l2, input int r2,
                      output int cnt[4]);
    cnt = '{0, 0, 0, 0};
    sync_start();
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      cnt[0] += int'(ifc.lft_fwd);
      cnt[1] += int'(ifc.lft_rev);
      cnt[2] += int'(ifc.rght_fwd);
      cnt[3] += int'(ifc.rght_rev);
      if (i == i1) drive(e1, l1, r1);
      if (i == i2) drive(e2, l2, r2);
    end
  endtask

  task automatic chk4(input string tag, input int cnt[4],
                      input int lf, input int lr, input int rf, input int rr);
    chk({tag, "_lf"}, cnt[0], lf);
    chk({tag, "_lr"}, cnt[1], lr);
    chk({tag, "_rf"}, cnt[2], rf);
    chk({tag, "_rr"}, cnt[3], rr);
  endtask

  function automatic logic signed [C_SPD_W-1:0] rnd_spd();
    int tbl[10] = '{-1024, -1023, -17, -16, -15, 0, 15, 16, 1023, 300};
    if ($urandom_range(0, 1) == 0) return C_SPD_W'(tbl[$urandom_range(0, 9)]);
    return C_SPD_W'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  int c[4];

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_outputs", int'({ifc.lft_fwd, ifc.lft_rev, ifc.rght_fwd,
                             ifc.rght_rev, ifc.prd_strt}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("prd_strt_first", int'(ifc.prd_strt), 1);

    // Reset mid-period while driving
    drive(1'b1, 500, 0);
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("fwd500", c, 500, 0, 0, 0);
    sync_start();
    repeat (100) @(negedge clk);
    chk("pre_rst_fwd", int'(ifc.lft_fwd), 1);
    #2 rst = 1'b1;
    #1 chk("async_rst", int'({ifc.lft_fwd, ifc.lft_rev, ifc.rght_fwd,
                              ifc.rght_rev, ifc.prd_strt}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("prd_strt_after_rst", int'(ifc.prd_strt), 1);

    // Steady +300 / -300
    drive(1'b1, 300, -300);
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("p300", c, 300, 0, 0, 300);

    // Reversal +300 -> -200 mid-period: finish, gap, then reverse
    meas(500, 1, -200, -300, -1, 1, 0, 0, c);
    chk4("rev_cur", c, 300, 0, 0, 300);
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("rev_gap", c, 0, 0, 0, 300);
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("rev_new", c, 0, 200, 0, 300);

    // Saturation and deadband
    meas(500, 1, -1024, -300, -1, 1, 0, 0, c);
    chk("sat_prev_lr", c[1], 200);
    meas(500, 1, 15, -300, -1, 1, 0, 0, c);
    chk("sat_lr", c[1], 1023);
    meas(500, 1, 16, -300, -1, 1, 0, 0, c);
    chk4("dead15", c, 0, 0, 0, 300);
    meas(499, 1, 400, -300, -1, 1, 0, 0, c);
    chk("min16_lf", c[0], 16);

    // Mid-period change 400 -> 100 waits for the boundary
    meas(499, 1, 100, -300, -1, 1, 0, 0, c);
    chk("d400_lf", c[0], 400);
    meas(500, 1, 300, -300, -1, 1, 0, 0, c);
    chk("d100_lf", c[0], 100);

    // Enable drop at cnt 50, re-enable mid-period
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("en_pre", c, 300, 0, 0, 300);
    meas(49, 0, 300, -300, 500, 1, 300, -300, c);
    chk4("en_drop", c, 50, 0, 0, 50);
    meas(-1, 1, 0, 0, -1, 1, 0, 0, c);
    chk4("en_resume", c, 300, 0, 0, 300);

    // Random phase
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (n == 15000) #2 rst = 1'b1;
      else if (n == 15003) rst = 1'b0;
      if ($urandom_range(0, 299) == 0) ifc.lft_spd = rnd_spd();
      if ($urandom_range(0, 299) == 0) ifc.rght_spd = rnd_spd();
      if (ifc.en) begin
        if ($urandom_range(0, 3999) == 0) ifc.en = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        ifc.en = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
